// File: rtl/dsp_dot_sequencer.sv
// ============================================================================
// dsp_dot_sequencer : drives one fully-registered DSP slice to compute
//                     bias + sum(a*b) per vector, results via a small FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module dsp_dot_sequencer #(
   parameter int DSP_LAT    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [26:0] in_a,
   input  logic signed [17:0] in_b,
   input  logic signed [47:0] in_bias,
   input  logic               in_last,
   output logic               dsp_en,
   output logic signed [29:0] dsp_a,
   output logic signed [17:0] dsp_b,
   output logic signed [47:0] dsp_c,
   output logic        [26:0] dsp_d,
   output logic        [8:0]  dsp_opmode,
   output logic        [4:0]  dsp_inmode,
   output logic        [3:0]  dsp_alumode,
   input  logic signed [47:0] dsp_p,
   output logic               res_valid,
   input  logic               res_ready,
   output logic signed [47:0] res_data
);

   localparam int c_aw = $clog2(FIFO_DEPTH);
   localparam int c_cw = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_cw-1:0] c_depth    = c_cw'(FIFO_DEPTH);
   localparam logic [8:0]      c_op_first = 9'h185;
   localparam logic [8:0]      c_op_acc   = 9'h025;

   logic                     r_first;
   logic                     r_slot_first;
   logic signed [47:0]       r_slot_bias;
   logic [DSP_LAT:0]         r_tag;
   logic [c_cw-1:0]          r_pending;
   logic [c_cw-1:0]          r_count;
   logic [c_aw-1:0]          r_wr;
   logic [c_aw-1:0]          r_rd;
   logic signed [47:0]       r_mem [FIFO_DEPTH];

   logic w_accept;
   logic w_accept_last;
   logic w_push;
   logic w_pop;

   assign w_accept      = in_valid & in_ready;
   assign w_accept_last = w_accept & in_last;
   assign w_push        = r_tag[DSP_LAT];
   assign w_pop         = res_valid & res_ready;

   // Pending counts every accepted vector end not yet popped, so the FIFO can
   // never be asked to take a result it has no room for.
   assign in_ready    = !rst && (r_pending < c_depth);
   assign dsp_en      = !rst;
   assign dsp_d       = '0;
   assign dsp_inmode  = 5'b00000;
   assign dsp_alumode = 4'b0000;
   assign res_valid   = (r_count != '0);
   assign res_data    = res_valid ? r_mem[r_rd] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_first      <= 1'b1;
         r_slot_first <= 1'b0;
         r_slot_bias  <= '0;
         r_tag        <= '0;
         r_pending    <= '0;
         r_count      <= '0;
         r_wr         <= '0;
         r_rd         <= '0;
         dsp_a        <= '0;
         dsp_b        <= '0;
         dsp_c        <= '0;
         dsp_opmode   <= c_op_acc;
      end else begin
         if (w_accept) begin
            dsp_a   <= {{3{in_a[26]}}, in_a};
            dsp_b   <= in_b;
            r_first <= in_last;
         end else begin
            dsp_a   <= '0;
            dsp_b   <= '0;
         end

         // Opmode and C trail the operands by one cycle to meet M at the ALU.
         r_slot_first <= w_accept & r_first;
         r_slot_bias  <= in_bias;
         dsp_opmode   <= r_slot_first ? c_op_first : c_op_acc;
         dsp_c        <= r_slot_first ? r_slot_bias : '0;

         r_tag <= {r_tag[DSP_LAT-1:0], w_accept_last};

         case ({w_accept_last, w_pop})
            2'b10:   r_pending <= r_pending + 1'b1;
            2'b01:   r_pending <= r_pending - 1'b1;
            default: r_pending <= r_pending;
         endcase

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst) r_mem[r_wr] <= dsp_p;
   end

endmodule

`default_nettype wire

// File: tb/tb_dsp_dot_sequencer.sv
// ============================================================================
// tb_dsp_dot_sequencer : table vectors, hand sequences and random traffic
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dsp_dot_sequencer;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [26:0] in_a = '0;
   logic signed [17:0] in_b = '0;
   logic signed [47:0] in_bias = '0;
   logic               in_last = 1'b0;
   logic               dsp_en;
   logic signed [29:0] dsp_a;
   logic signed [17:0] dsp_b;
   logic signed [47:0] dsp_c;
   logic        [26:0] dsp_d;
   logic        [8:0]  dsp_opmode;
   logic        [4:0]  dsp_inmode;
   logic        [3:0]  dsp_alumode;
   logic signed [47:0] dsp_p;
   logic               res_valid;
   logic               res_ready = 1'b1;
   logic signed [47:0] res_data;

   dsp_dot_sequencer #(.DSP_LAT(3), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_last(in_last),
      .dsp_en(dsp_en), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
      .dsp_opmode(dsp_opmode), .dsp_inmode(dsp_inmode), .dsp_alumode(dsp_alumode),
      .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   // DSP slice with A/B, M, P, OPMODE and C registers, all on one enable
   logic signed [29:0] m_ar = '0;
   logic signed [17:0] m_br = '0;
   logic signed [47:0] m_mr = '0;
   logic signed [47:0] m_cr = '0;
   logic signed [47:0] m_pr = '0;
   logic        [8:0]  m_opr = 9'h025;
   always @(posedge clk) begin
      if (dsp_en) begin
         m_ar  <= dsp_a;
         m_br  <= dsp_b;
         m_mr  <= m_ar * m_br;
         m_opr <= dsp_opmode;
         m_cr  <= dsp_c;
         m_pr  <= (m_opr == 9'h185) ? (m_mr + m_cr) : (m_pr + m_mr);
      end
   end
   assign dsp_p = m_pr;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   function automatic logic signed [47:0] mul(input logic signed [26:0] a, input logic signed [17:0] b);
      logic signed [47:0] aa;
      logic signed [47:0] bb;
      aa = a;
      bb = b;
      return aa * bb;
   endfunction

   // Reference: accumulate each vector arithmetically, compare results in order
   logic signed [47:0] exp_q[$];
   logic signed [47:0] got_q[$];
   logic signed [47:0] ref_sum = '0;
   bit                 ref_first = 1'b1;
   int                 acc_n = 0;
   int                 n185 = 0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         ref_first = 1'b1;
      end else begin
         if (dsp_opmode == 9'h185) n185++;
         if (in_valid && in_ready) begin
            if (ref_first) ref_sum = in_bias;
            ref_sum   = ref_sum + mul(in_a, in_b);
            ref_first = in_last;
            acc_n++;
            if (in_last) exp_q.push_back(ref_sum);
         end
         if (res_valid && res_ready) begin
            got_q.push_back(res_data);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got %0d required none", res_data);
            end else begin
               check("scoreboard", res_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic signed [26:0] a, input logic signed [17:0] b,
                       input logic signed [47:0] bias, input logic last);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_bias  = bias;
      in_last  = last;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 required 1");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_results(input int k, input string name);
      int n = 0;
      while (got_q.size() < k && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (got_q.size() < k) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d results required %0d", name, got_q.size(), k);
      end
   endtask

   typedef struct {
      int                  n;
      int                  gap;
      logic [3:0][26:0]    a;
      logic [3:0][17:0]    b;
      logic signed [47:0]  bias;
      logic signed [47:0]  exp;
   } vec_t;

   function automatic vec_t mk(input int n, input int gap,
                               input int a0, input int a1, input int a2, input int a3,
                               input int b0, input int b1, input int b2, input int b3,
                               input logic signed [47:0] bias, input logic signed [47:0] ex);
      vec_t v;
      v.n    = n;
      v.gap  = gap;
      v.a[0] = 27'(a0); v.a[1] = 27'(a1); v.a[2] = 27'(a2); v.a[3] = 27'(a3);
      v.b[0] = 18'(b0); v.b[1] = 18'(b1); v.b[2] = 18'(b2); v.b[3] = 18'(b3);
      v.bias = bias;
      v.exp  = ex;
      return v;
   endfunction

   vec_t tbl[6];
   bit   rnd_done = 1'b0;

   initial begin
      int lat;

      tbl[0] = mk(3, 0, 2, 3, -4, 0, 5, 6, 7, 0, 48'sd10, 48'sd10);
      tbl[1] = mk(3, 2, 2, 3, -4, 0, 5, 6, 7, 0, 48'sd10, 48'sd10);
      tbl[2] = mk(1, 0, -67108864, 0, 0, 0, -131072, 0, 0, 0,
                  48'sh7FFF_FFFF_FFFF, 48'sh87FF_FFFF_FFFF);
      tbl[3] = mk(4, 1, 100, -7, 0, 1, -3, 9, 5, -1, -48'sd50, -48'sd414);
      tbl[4] = mk(1, 0, 3, 0, 0, 0, 3, 0, 0, 0, 48'sd0, 48'sd9);
      tbl[5] = mk(2, 0, 67108863, 67108863, 0, 0, 131071, 131071, 0, 0,
                  48'sd0, 48'sd17592051564546);

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_dsp_en", dsp_en, 0);
      check("rst_dsp_a", dsp_a, 0);
      check("rst_dsp_b", dsp_b, 0);
      check("rst_dsp_c", dsp_c, 0);
      check("rst_dsp_d", dsp_d, 0);
      check("rst_opmode", dsp_opmode, 9'h025);
      check("rst_inmode", dsp_inmode, 0);
      check("rst_alumode", dsp_alumode, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      check("en_after_rst", dsp_en, 1);

      // table-driven vectors
      for (int t = 0; t < 6; t++) begin
         got_q.delete();
         n185 = 0;
         for (int i = 0; i < tbl[t].n; i++) begin
            send(tbl[t].a[i], tbl[t].b[i], tbl[t].bias, i == tbl[t].n - 1);
            if (i < tbl[t].n - 1) idle(tbl[t].gap);
         end
         lat = 0;
         while (!res_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check($sformatf("vec%0d_latency", t), lat, 4);
         wait_results(1, $sformatf("vec%0d", t));
         idle(2);
         check($sformatf("vec%0d_result", t), got_q[0], tbl[t].exp);
         check($sformatf("vec%0d_count", t), got_q.size(), 1);
         check($sformatf("vec%0d_first_slots", t), n185, 1);
      end

      // operand / opmode alignment
      got_q.delete();
      send(-27'sd5, 18'sd7, 48'sd123, 1'b1);
      check("align_a", dsp_a, -5);
      check("align_b", dsp_b, 7);
      check("align_op0", dsp_opmode, 9'h025);
      check("align_c0", dsp_c, 0);
      idle(1);
      check("align_op1", dsp_opmode, 9'h185);
      check("align_c1", dsp_c, 123);
      check("align_bubble_a", dsp_a, 0);
      idle(1);
      check("align_op2", dsp_opmode, 9'h025);
      check("align_c2", dsp_c, 0);
      wait_results(1, "align");
      check("align_result", got_q[0], 88);

      // back-to-back length-1 vectors
      got_q.delete();
      for (int k = 0; k < 8; k++) send(27'sd1, 18'sd1, 48'(k), 1'b1);
      wait_results(8, "burst");
      for (int i = 0; i < 8; i++) check($sformatf("burst%0d", i), got_q[i], i + 1);

      // result backpressure
      got_q.delete();
      res_ready = 1'b0;
      lat = acc_n;
      for (int k = 0; k < 4; k++) send(27'sd1, 18'sd1, 48'(10 * k), 1'b1);
      in_valid = 1'b1;
      in_bias  = 48'sd40;
      idle(10);
      check("bp_accepted", acc_n - lat, 4);
      check("bp_in_ready", in_ready, 0);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 1);
      res_ready = 1'b1;
      send(27'sd1, 18'sd1, 48'sd40, 1'b1);
      send(27'sd1, 18'sd1, 48'sd50, 1'b1);
      wait_results(6, "bp");
      for (int i = 0; i < 6; i++) check($sformatf("bp%0d", i), got_q[i], 10 * i + 1);

      // reset mid-vector with a result parked in the FIFO
      idle(4);
      got_q.delete();
      res_ready = 1'b0;
      send(27'sd2, 18'sd2, 48'sd0, 1'b1);
      send(27'sd5, 18'sd5, 48'sd100, 1'b0);
      send(27'sd6, 18'sd6, 48'sd0, 1'b0);
      idle(6);
      check("pre_rst_res_valid", res_valid, 1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("post_rst_res_valid", res_valid, 0);
      res_ready = 1'b1;
      idle(10);
      check("post_rst_no_result", got_q.size(), 0);
      send(27'sd3, 18'sd3, 48'sd0, 1'b1);
      wait_results(1, "post_rst");
      idle(3);
      check("post_rst_result", got_q[0], 9);
      check("post_rst_count", got_q.size(), 1);

      // random traffic against the reference
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(27'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
                    ($urandom_range(0, 3) == 0) || (i == 299));
               idle($urandom_range(0, 2));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               res_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      res_ready = 1'b1;
      lat = 0;
      while (exp_q.size() != 0 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("random_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      bad++;
      $display("FAIL watchdog: got timeout required completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
